// File: rtl/exu_alu_pipe.sv
// Pipelined integer ALU execution unit: one op per cycle in, one registered writeback out.
// Shifts run through a barrel shifter or, when SERIAL_SHIFT=1, one bit position per cycle.
module exu_alu_pipe #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RFIDX        = 5,
  parameter int unsigned SERIAL_SHIFT = 0
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_op,
  input  logic             i_rdwen,
  input  logic [RFIDX-1:0] i_rdidx,
  input  logic [XLEN-1:0]  i_op1,
  input  logic [XLEN-1:0]  i_op2,
  output logic [XLEN-1:0]  o_lsu_result,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_rdwen,
  output logic [RFIDX-1:0] o_rdidx,
  output logic [XLEN-1:0]  o_rdwdata
);

  localparam int unsigned ShW      = $clog2(XLEN);
  localparam bit          SerialEn = (SERIAL_SHIFT != 0);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpSll  = 4'd2;
  localparam logic [3:0] OpSrl  = 4'd3;
  localparam logic [3:0] OpSra  = 4'd4;
  localparam logic [3:0] OpXor  = 4'd5;
  localparam logic [3:0] OpAnd  = 4'd6;
  localparam logic [3:0] OpOr   = 4'd7;
  localparam logic [3:0] OpSlt  = 4'd8;
  localparam logic [3:0] OpSltu = 4'd9;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StHold  = 2'd2
  } state_e;

  state_e           r_state, w_state_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_rdwen, w_rdwen_nxt;
  logic [RFIDX-1:0] r_rdidx, w_rdidx_nxt;
  logic [XLEN-1:0]  r_rdwdata, w_rdwdata_nxt;

  // Serial shifter working state; the destination is parked here until the shift completes.
  logic [XLEN-1:0]  r_sh_data, w_sh_data_nxt;
  logic [ShW-1:0]   r_sh_cnt, w_sh_cnt_nxt;
  logic [3:0]       r_sh_op, w_sh_op_nxt;
  logic             r_sh_rdwen, w_sh_rdwen_nxt;
  logic [RFIDX-1:0] r_sh_rdidx, w_sh_rdidx_nxt;

  logic [ShW-1:0]   w_shamt;
  logic             w_is_shift;
  logic             w_start_serial;
  logic             w_accept;
  logic             w_lt_s, w_lt_u;
  logic [XLEN-1:0]  w_alu_res;
  logic [XLEN-1:0]  w_sh_step;

  assign w_shamt        = i_op2[ShW-1:0];
  assign w_is_shift     = (i_op == OpSll) || (i_op == OpSrl) || (i_op == OpSra);
  assign w_start_serial = SerialEn && w_is_shift && (w_shamt != '0);

  assign o_ready  = (r_state == StIdle) || ((r_state == StHold) && i_ready);
  assign w_accept = i_valid && o_ready && !i_flush;

  assign o_lsu_result = i_op1 + i_op2;

  assign w_lt_s = $signed(i_op1) < $signed(i_op2);
  assign w_lt_u = i_op1 < i_op2;

  always_comb begin
    w_alu_res = '0;
    unique case (i_op)
      OpAdd:   w_alu_res = i_op1 + i_op2;
      OpSub:   w_alu_res = i_op1 - i_op2;
      OpSll:   w_alu_res = i_op1 << w_shamt;
      OpSrl:   w_alu_res = i_op1 >> w_shamt;
      OpSra:   w_alu_res = $unsigned($signed(i_op1) >>> w_shamt);
      OpXor:   w_alu_res = i_op1 ^ i_op2;
      OpAnd:   w_alu_res = i_op1 & i_op2;
      OpOr:    w_alu_res = i_op1 | i_op2;
      OpSlt:   w_alu_res = {{(XLEN-1){1'b0}}, w_lt_s};
      OpSltu:  w_alu_res = {{(XLEN-1){1'b0}}, w_lt_u};
      default: w_alu_res = '0;
    endcase
  end

  always_comb begin
    w_sh_step = r_sh_data;
    unique case (r_sh_op)
      OpSll:   w_sh_step = {r_sh_data[XLEN-2:0], 1'b0};
      OpSrl:   w_sh_step = {1'b0, r_sh_data[XLEN-1:1]};
      default: w_sh_step = {r_sh_data[XLEN-1], r_sh_data[XLEN-1:1]};
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_valid_nxt    = r_valid;
    w_rdwen_nxt    = r_rdwen;
    w_rdidx_nxt    = r_rdidx;
    w_rdwdata_nxt  = r_rdwdata;
    w_sh_data_nxt  = r_sh_data;
    w_sh_cnt_nxt   = r_sh_cnt;
    w_sh_op_nxt    = r_sh_op;
    w_sh_rdwen_nxt = r_sh_rdwen;
    w_sh_rdidx_nxt = r_sh_rdidx;

    if (i_flush) begin
      w_state_nxt = StIdle;
      w_valid_nxt = 1'b0;
      w_rdwen_nxt = 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StHold: begin
          if ((r_state == StHold) && i_ready) begin
            w_state_nxt = StIdle;
            w_valid_nxt = 1'b0;
            w_rdwen_nxt = 1'b0;
          end
          if (w_accept) begin
            if (w_start_serial) begin
              w_state_nxt    = StShift;
              w_sh_data_nxt  = i_op1;
              w_sh_cnt_nxt   = w_shamt;
              w_sh_op_nxt    = i_op;
              w_sh_rdwen_nxt = i_rdwen;
              w_sh_rdidx_nxt = i_rdidx;
            end else begin
              w_state_nxt   = StHold;
              w_valid_nxt   = 1'b1;
              w_rdwen_nxt   = i_rdwen;
              w_rdidx_nxt   = i_rdidx;
              w_rdwdata_nxt = w_alu_res;
            end
          end
        end
        StShift: begin
          // Final step lands straight in the output register, giving shamt+1 total latency.
          w_sh_data_nxt = w_sh_step;
          w_sh_cnt_nxt  = r_sh_cnt - ShW'(1);
          if (r_sh_cnt == ShW'(1)) begin
            w_state_nxt   = StHold;
            w_valid_nxt   = 1'b1;
            w_rdwen_nxt   = r_sh_rdwen;
            w_rdidx_nxt   = r_sh_rdidx;
            w_rdwdata_nxt = w_sh_step;
          end
        end
        default: begin
          w_state_nxt = StIdle;
          w_valid_nxt = 1'b0;
          w_rdwen_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= StIdle;
      r_valid    <= 1'b0;
      r_rdwen    <= 1'b0;
      r_rdidx    <= '0;
      r_rdwdata  <= '0;
      r_sh_data  <= '0;
      r_sh_cnt   <= '0;
      r_sh_op    <= '0;
      r_sh_rdwen <= 1'b0;
      r_sh_rdidx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_valid    <= w_valid_nxt;
      r_rdwen    <= w_rdwen_nxt;
      r_rdidx    <= w_rdidx_nxt;
      r_rdwdata  <= w_rdwdata_nxt;
      r_sh_data  <= w_sh_data_nxt;
      r_sh_cnt   <= w_sh_cnt_nxt;
      r_sh_op    <= w_sh_op_nxt;
      r_sh_rdwen <= w_sh_rdwen_nxt;
      r_sh_rdidx <= w_sh_rdidx_nxt;
    end
  end

  assign o_valid   = r_valid;
  assign o_rdwen   = r_rdwen;
  assign o_rdidx   = r_rdidx;
  assign o_rdwdata = r_rdwdata;

endmodule

// File: tb/tb_exu_alu_pipe.sv
// Directed bench for exu_alu_pipe: one barrel-shifter instance and one serial-shifter instance.
module tb_exu_alu_pipe;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SRL  = 4'd3;
  localparam logic [3:0] OP_SRA  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        rdwen;
    logic [4:0]  rdidx;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        valid_b, valid_s;
  logic        rdy;
  logic [3:0]  op;
  logic        rdwen;
  logic [4:0]  rdidx;
  logic [31:0] op1, op2;

  logic        o_ready_b, o_valid_b, o_rdwen_b;
  logic [4:0]  o_rdidx_b;
  logic [31:0] o_rdwdata_b, o_lsu_b;
  logic        o_ready_s, o_valid_s, o_rdwen_s;
  logic [4:0]  o_rdidx_s;
  logic [31:0] o_rdwdata_s, o_lsu_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exu_alu_pipe #(.XLEN(32), .RFIDX(5), .SERIAL_SHIFT(0)) u_dut_b (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_valid(valid_b), .o_ready(o_ready_b),
    .i_op(op), .i_rdwen(rdwen), .i_rdidx(rdidx), .i_op1(op1), .i_op2(op2),
    .o_lsu_result(o_lsu_b), .o_valid(o_valid_b), .i_ready(rdy), .o_rdwen(o_rdwen_b),
    .o_rdidx(o_rdidx_b), .o_rdwdata(o_rdwdata_b)
  );

  exu_alu_pipe #(.XLEN(32), .RFIDX(5), .SERIAL_SHIFT(1)) u_dut_s (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_valid(valid_s), .o_ready(o_ready_s),
    .i_op(op), .i_rdwen(rdwen), .i_rdidx(rdidx), .i_op1(op1), .i_op2(op2),
    .o_lsu_result(o_lsu_s), .o_valid(o_valid_s), .i_ready(rdy), .o_rdwen(o_rdwen_s),
    .o_rdidx(o_rdidx_s), .o_rdwdata(o_rdwdata_s)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    op    = v.op;
    op1   = v.op1;
    op2   = v.op2;
    rdwen = v.rdwen;
    rdidx = v.rdidx;
  endtask

  // Issue one op to the serial instance and measure accept-to-valid latency.
  task automatic serial_run(input vec_t v, output int lat, output int rdy_hi);
    drive(v);
    rdy     = 1'b1;
    valid_s = 1'b1;
    #1;
    chk("ser_ready_before", {31'b0, o_ready_s}, 32'd1);
    step();
    valid_s = 1'b0;
    lat     = 0;
    rdy_hi  = 0;
    for (int k = 1; k <= 40; k++) begin
      if (o_valid_s) begin
        lat = k;
        break;
      end
      if (o_ready_s) rdy_hi++;
      step();
    end
  endtask

  vec_t vt[13];
  vec_t bp[4];
  vec_t sv;
  int   lat, rdy_hi, idx, got, stall_left, vcount;
  bit   seen, acc;
  int   tcons[4];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000002, 1'b1, 5'd7,  32'h00000001};
    vt[1]  = '{OP_SUB,  32'h00000005, 32'h00000007, 1'b1, 5'd1,  32'hFFFFFFFE};
    vt[2]  = '{OP_SLL,  32'h00000001, 32'h00000021, 1'b1, 5'd2,  32'h00000002};
    vt[3]  = '{OP_SRA,  32'h80000000, 32'h00000004, 1'b1, 5'd3,  32'hF8000000};
    vt[4]  = '{OP_SRL,  32'h80000000, 32'h00000004, 1'b1, 5'd4,  32'h08000000};
    vt[5]  = '{OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd5,  32'h0FF00FF0};
    vt[6]  = '{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 5'd6,  32'hF000F000};
    vt[7]  = '{OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd8,  32'hFFF0FFF0};
    vt[8]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 1'b1, 5'd9,  32'h00000001};
    vt[9]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 1'b1, 5'd10, 32'h00000000};
    vt[10] = '{4'd12,   32'h00000123, 32'h00000456, 1'b1, 5'd11, 32'h00000000};
    vt[11] = '{OP_SLL,  32'h00000003, 32'h0000001F, 1'b1, 5'd12, 32'h80000000};
    vt[12] = '{OP_SRL,  32'hDEADBEEF, 32'h00000020, 1'b1, 5'd13, 32'hDEADBEEF};

    bp[0] = '{OP_XOR, 32'h0000FFFF, 32'h00FF00FF, 1'b1, 5'd1, 32'h00FFFF00};
    bp[1] = '{OP_AND, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b1, 5'd2, 32'h30303030};
    bp[2] = '{OP_OR,  32'h12000000, 32'h00000034, 1'b1, 5'd3, 32'h12000034};
    bp[3] = '{OP_SUB, 32'h00000010, 32'h00000020, 1'b1, 5'd4, 32'hFFFFFFF0};

    rstn = 1'b0; flush = 1'b0; valid_b = 1'b0; valid_s = 1'b0; rdy = 1'b1;
    op = '0; rdwen = 1'b0; rdidx = '0; op1 = '0; op2 = '0;
    #2;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("rst_valid",  {31'b0, o_valid_b}, 32'd0);
    chk("rst_rdwen",  {31'b0, o_rdwen_b}, 32'd0);
    chk("rst_rdidx",  {27'b0, o_rdidx_b}, 32'd0);
    chk("rst_rdwdata", o_rdwdata_b, 32'd0);
    step();
    rstn = 1'b1;
    step();
    chk("rst_ready_b", {31'b0, o_ready_b}, 32'd1);
    chk("rst_ready_s", {31'b0, o_ready_s}, 32'd1);

    // Lsu address path ignores valid and state.
    op1 = 32'h7FFFFFFF; op2 = 32'h00000001;
    #1;
    chk("lsu_idle", o_lsu_b, 32'h80000000);

    for (int i = 0; i < 13; i++) begin
      drive(vt[i]);
      valid_b = 1'b1;
      #1;
      chk($sformatf("v%0d_lsu", i), o_lsu_b, vt[i].op1 + vt[i].op2);
      step();
      valid_b = 1'b0;
      chk($sformatf("v%0d_valid", i), {31'b0, o_valid_b}, 32'd1);
      chk($sformatf("v%0d_data", i), o_rdwdata_b, vt[i].exp);
      chk($sformatf("v%0d_rdidx", i), {27'b0, o_rdidx_b}, {27'b0, vt[i].rdidx});
      chk($sformatf("v%0d_rdwen", i), {31'b0, o_rdwen_b}, {31'b0, vt[i].rdwen});
      step();
      chk($sformatf("v%0d_drain", i), {31'b0, o_valid_b}, 32'd0);
    end

    // Backpressure: four ops streamed, writeback stalls 3 cycles after the first result.
    idx = 0; got = 0; stall_left = 0; seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (o_valid_b && !seen) begin
        seen       = 1'b1;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = 1'b1;
      end
      #1;
      if (o_valid_b) begin
        if (!rdy) begin
          chk("bp_stall_ready", {31'b0, o_ready_b}, 32'd0);
          chk("bp_stall_data", o_rdwdata_b, bp[0].exp);
          chk("bp_stall_rdidx", {27'b0, o_rdidx_b}, {27'b0, bp[0].rdidx});
        end else begin
          if (got < 4) begin
            chk($sformatf("bp_res%0d", got), o_rdwdata_b, bp[got].exp);
            chk($sformatf("bp_idx%0d", got), {27'b0, o_rdidx_b}, {27'b0, bp[got].rdidx});
            tcons[got] = c;
          end
          got++;
        end
      end
      valid_b = (idx < 4);
      if (idx < 4) drive(bp[idx]);
      #1;
      acc = valid_b && o_ready_b;
      step();
      if (acc) idx++;
    end
    valid_b = 1'b0;
    rdy     = 1'b1;
    chk("bp_count", got, 32'd4);
    chk("bp_throughput", tcons[3] - tcons[0], 32'd3);

    // Serial shifter latency.
    sv = '{OP_SRL, 32'hF0000000, 32'd31, 1'b1, 5'd9, 32'h00000001};
    serial_run(sv, lat, rdy_hi);
    chk("ser31_lat", lat, 32'd32);
    chk("ser31_data", o_rdwdata_s, 32'h00000001);
    chk("ser31_rdidx", {27'b0, o_rdidx_s}, 32'd9);
    chk("ser31_busy_ready", rdy_hi, 32'd0);
    step();
    chk("ser31_drain", {31'b0, o_valid_s}, 32'd0);

    sv = '{OP_SRA, 32'h80000000, 32'd4, 1'b1, 5'd14, 32'hF8000000};
    serial_run(sv, lat, rdy_hi);
    chk("ser_sra_lat", lat, 32'd5);
    chk("ser_sra_data", o_rdwdata_s, 32'hF8000000);
    step();

    sv = '{OP_SLL, 32'h0000ABCD, 32'h00000040, 1'b1, 5'd15, 32'h0000ABCD};
    serial_run(sv, lat, rdy_hi);
    chk("ser_sh0_lat", lat, 32'd1);
    chk("ser_sh0_data", o_rdwdata_s, 32'h0000ABCD);
    step();

    // Flush mid-shift with a new add presented in the same cycle.
    drive('{OP_SRL, 32'hF0000000, 32'd31, 1'b1, 5'd9, 32'h0});
    valid_s = 1'b1;
    step();
    valid_s = 1'b0;
    for (int k = 1; k < 5; k++) step();
    drive('{OP_ADD, 32'h1, 32'h1, 1'b1, 5'd3, 32'h2});
    flush   = 1'b1;
    valid_s = 1'b1;
    step();
    flush   = 1'b0;
    valid_s = 1'b0;
    chk("flush_valid", {31'b0, o_valid_s}, 32'd0);
    chk("flush_rdwen", {31'b0, o_rdwen_s}, 32'd0);
    chk("flush_ready", {31'b0, o_ready_s}, 32'd1);
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_valid_s) vcount++;
      step();
    end
    chk("flush_no_result", vcount, 32'd0);

    // Async reset while holding a result.
    drive('{OP_ADD, 32'h2, 32'h3, 1'b1, 5'd4, 32'h5});
    valid_b = 1'b1;
    step();
    valid_b = 1'b0;
    rdy     = 1'b0;
    chk("hold_valid", {31'b0, o_valid_b}, 32'd1);
    chk("hold_data", o_rdwdata_b, 32'h5);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", {31'b0, o_valid_b}, 32'd0);
    chk("arst_rdwen", {31'b0, o_rdwen_b}, 32'd0);
    chk("arst_data", o_rdwdata_b, 32'd0);
    #3;
    rstn = 1'b1;
    rdy  = 1'b1;
    step();
    chk("arst_ready", {31'b0, o_ready_b}, 32'd1);
    chk("arst_idle", {31'b0, o_valid_b}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
